counter_nbit: RTL
=================

# counter_nbit

Parametrised up/down counter generalising the team's 4-bit loadable counter: configurable width and terminal value, direction control, wrap or saturate mode, a registered terminal-count pulse, and an optional enable prescaler. Drives switch/LED lab tops directly and serves as the reusable counting element for timers, BCD digit chains and address generators elsewhere in the design.

## Interface
- WIDTH, 4, counter width in bits (≥1)
- MAX, 2**WIDTH-1, terminal value; legal range 1..2**WIDTH-1; count range is 0..MAX
- PRESCALE, 1, enabled cycles per count step (≥1); used only when COUNTER_PRESCALE_EN is defined
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  count enable
- load  in  1  parallel load strobe
- up  in  1  direction: 1 = count up, 0 = count down
- saturate  in  1  boundary mode: 0 = wrap, 1 = hold at bound
- freshdata  in  WIDTH  parallel load value
- q  out  WIDTH  current count, registered
- tc  out  1  terminal-count pulse, registered, one cycle wide
- at_max  out  1  combinational, q == MAX
- at_zero  out  1  combinational, q == 0

## Operation
- Priority per rising edge: reset > load > step > hold.
- reset high (asynchronous, independent of clock): q = 0, tc = 0, prescaler count = 0; held while reset high.
- load = 1: q <= min(freshdata, MAX); prescaler count <= 0; tc <= 0; enable ignored that cycle.
- Step: occurs on an edge where load = 0 and step_ok = 1 (step_ok = enable without prescaler; see Configuration).
- Up step: q < MAX -> q+1; q == MAX -> 0 (wrap) or MAX (saturate).
- Down step: q > 0 -> q-1; q == 0 -> MAX (wrap) or 0 (saturate).
- tc <= 1 on any step taken at the bound in the current direction (up at MAX, down at 0), in either mode; otherwise tc <= 0.
- up and saturate are sampled each edge; changing them mid-count affects only the next step, never the prescaler.
- q never leaves 0..MAX; arithmetic is WIDTH bits, no carry out beyond tc.

## Timing
- q updates on the edge where the step/load is sampled; latency 1 cycle from enable/load to q.
- tc is high for exactly the one cycle following the boundary step edge; consecutive boundary steps (e.g. saturate with enable held) give tc high on consecutive cycles.
- at_max/at_zero follow q combinationally, same cycle as q.
- Reset deassertion: first step can occur on the first rising edge with reset low.
- Reset asserted mid-prescale or mid-tc clears all state immediately, no clock required.

## Configuration
- Macro: COUNTER_PRESCALE_EN.
- Defined: internal counter pcnt (0..PRESCALE-1, width clog2(PRESCALE), min 1 bit). On enable = 1 and load = 0: if pcnt == PRESCALE-1 then step_ok = 1 and pcnt <= 0, else pcnt <= pcnt+1. enable = 0 holds pcnt. PRESCALE = 1 behaves identically to undefined.
- Undefined: no prescaler logic; step_ok = enable; PRESCALE ignored.

## Test plan
- WIDTH=4, MAX=9, up=1, saturate=0, enable held 12 cycles from 0 -> q 1..9,0,1,2; tc high only in cycle after 9->0.
- Same, up=0 from q=2 -> q 1,0,9,8; tc high after 0->9; at_zero high while q=0.
- saturate=1, up=1, load freshdata=8 then enable 3 cycles -> q 9,9,9; tc high on 2nd and 3rd cycles; load freshdata=15 -> q=9 (clamped).
- load=1 and enable=1 same edge with freshdata=5 -> q=5, no step, tc=0; reset pulsed asynchronously between edges with q=7 -> q=0, tc=0 immediately.
- COUNTER_PRESCALE_EN, PRESCALE=3, enable held 9 cycles from 0 -> q increments on cycles 3,6,9 only; enable dropped after 2 cycles then restored -> next step after 1 more enabled cycle.
- COUNTER_PRESCALE_EN undefined, PRESCALE=3 -> q increments every enabled cycle.

Source files
------------

// File: rtl/counter_nbit.sv
// counter_nbit: parametrised up/down counter with load, wrap/saturate bounds,
// registered terminal-count pulse. Optional prescaler via COUNTER_PRESCALE_EN.
module counter_nbit #(
  parameter int WIDTH    = 4,
  parameter int MAX      = 2**WIDTH-1,
  parameter int PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic             up,
  input  logic             saturate,
  input  logic [WIDTH-1:0] freshdata,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic             step_ok;
  logic [WIDTH-1:0] q_next;
  logic             tc_next;

`ifdef COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE-1);

  logic [PW-1:0] pcnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      pcnt <= '0;
    else if (load)
      pcnt <= '0;
    else if (enable)
      pcnt <= (pcnt == PLAST) ? '0 : pcnt + PW'(1);
  end

  assign step_ok = enable && (pcnt == PLAST);
`else
  assign step_ok = enable;
`endif

  always_comb begin
    q_next  = q;
    tc_next = 1'b0;
    if (load) begin
      q_next = (freshdata > MAX_V) ? MAX_V : freshdata;
    end else if (step_ok) begin
      if (up) begin
        if (q == MAX_V) begin
          tc_next = 1'b1;
          q_next  = saturate ? MAX_V : '0;
        end else begin
          q_next = q + WIDTH'(1);
        end
      end else begin
        if (q == '0) begin
          tc_next = 1'b1;
          q_next  = saturate ? '0 : MAX_V;
        end else begin
          q_next = q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q  <= '0;
      tc <= 1'b0;
    end else begin
      q  <= q_next;
      tc <= tc_next;
    end
  end

  assign at_max  = (q == MAX_V);
  assign at_zero = (q == '0);

endmodule
